lc3b_agex_stage: RTL and testbench

- Address-generation/execute (AGEX) stage of the 5-stage LC-3b pipeline.
- Combinationally computes the memory address and the ALU/shifter result from the AGEX latch contents, and drives the next-state values of the MEM latch.
- Owns the AGEX→MEM pipeline latch, which loads unless MEM stalls.
- Drives valid-gated hazard signals back to the decode/fetch stages.

---
 rtl/lc3b_agex_stage.sv | 147 ++++++++++++++
 tb/tb_lc3b_agex_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_agex_stage.sv
// LC-3b AGEX stage: address adder, ALU and shifter feeding the AGEX->MEM latch.
// Zero-latency combinational next-state; latch loads each cycle unless MEM stalls (holds on stall).
module lc3b_agex_stage #(
    parameter int CS_W     = 20,
    parameter int MEM_CS_W = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                agex_v,
    input  logic [15:0]         agex_npc,
    input  logic [15:0]         agex_ir,
    input  logic [15:0]         agex_sr1,
    input  logic [15:0]         agex_sr2,
    input  logic [2:0]          agex_cc,
    input  logic [2:0]          agex_drid,
    input  logic [CS_W-1:0]     agex_cs,
    input  logic                mem_stall,
    output logic                ld_mem,
    output logic                mem_v_in,
    output logic [15:0]         mem_npc_in,
    output logic [15:0]         mem_ir_in,
    output logic [15:0]         mem_alu_result_in,
    output logic [15:0]         mem_address_in,
    output logic [2:0]          mem_cc_in,
    output logic [2:0]          mem_drid_in,
    output logic [MEM_CS_W-1:0] mem_cs_in,
    output logic                mem_v,
    output logic [15:0]         mem_npc,
    output logic [15:0]         mem_ir,
    output logic [15:0]         mem_alu_result,
    output logic [15:0]         mem_address,
    output logic [2:0]          mem_cc,
    output logic [2:0]          mem_drid,
    output logic [MEM_CS_W-1:0] mem_cs,
    output logic                v_agex_ld_reg,
    output logic                v_agex_ld_cc,
    output logic                v_agex_br_stall
);

    logic        addr1mux, lshf1, addressmux, sr2mux, resultmux;
    logic [1:0]  addr2mux, aluk;
    logic [15:0] addr1, addr2, addr2_sh, addr_sum;
    logic [15:0] alu_b, alu_out, shf_out;
    logic [3:0]  shamt;

    // Two-bit mux selects are stored MSB-first at ascending indices.
    assign addr1mux   = agex_cs[0];
    assign addr2mux   = {agex_cs[1], agex_cs[2]};
    assign lshf1      = agex_cs[3];
    assign addressmux = agex_cs[4];
    assign sr2mux     = agex_cs[5];
    assign aluk       = {agex_cs[6], agex_cs[7]};
    assign resultmux  = agex_cs[8];

    assign addr1 = addr1mux ? agex_sr1 : agex_npc;

    always_comb begin
        addr2 = 16'h0000;
        case (addr2mux)
            2'b00: addr2 = 16'h0000;
            2'b01: addr2 = {{10{agex_ir[5]}}, agex_ir[5:0]};
            2'b10: addr2 = {{7{agex_ir[8]}}, agex_ir[8:0]};
            2'b11: addr2 = {{5{agex_ir[10]}}, agex_ir[10:0]};
            default: addr2 = 16'h0000;
        endcase
    end

    assign addr2_sh       = lshf1 ? {addr2[14:0], 1'b0} : addr2;
    assign addr_sum       = addr1 + addr2_sh;
    assign mem_address_in = addressmux ? addr_sum : {7'b0, agex_ir[7:0], 1'b0};

    assign alu_b = sr2mux ? {{11{agex_ir[4]}}, agex_ir[4:0]} : agex_sr2;

    always_comb begin
        alu_out = agex_sr1;
        case (aluk)
            2'b00: alu_out = agex_sr1 + alu_b;
            2'b01: alu_out = agex_sr1 & alu_b;
            2'b10: alu_out = agex_sr1 ^ alu_b;
            2'b11: alu_out = agex_sr1;
            default: alu_out = agex_sr1;
        endcase
    end

    assign shamt = agex_ir[3:0];

    always_comb begin
        shf_out = agex_sr1 << shamt;
        if (agex_ir[4]) begin
            if (agex_ir[5])
                shf_out = 16'($signed(agex_sr1) >>> shamt);
            else
                shf_out = agex_sr1 >> shamt;
        end
    end

    assign mem_alu_result_in = resultmux ? alu_out : shf_out;

    assign mem_v_in    = agex_v;
    assign mem_npc_in  = agex_npc;
    assign mem_ir_in   = agex_ir;
    assign mem_cc_in   = agex_cc;
    assign mem_drid_in = agex_drid;
    assign mem_cs_in   = agex_cs[19:9];
    assign ld_mem      = ~mem_stall;

    assign v_agex_ld_reg   = agex_v & agex_cs[18];
    assign v_agex_ld_cc    = agex_v & agex_cs[19];
    assign v_agex_br_stall = agex_v & agex_cs[12];

    logic                mem_v_q;
    logic [15:0]         mem_npc_q, mem_ir_q, mem_alu_result_q, mem_address_q;
    logic [2:0]          mem_cc_q, mem_drid_q;
    logic [MEM_CS_W-1:0] mem_cs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_v_q          <= 1'b0;
            mem_npc_q        <= 16'h0000;
            mem_ir_q         <= 16'h0000;
            mem_alu_result_q <= 16'h0000;
            mem_address_q    <= 16'h0000;
            mem_cc_q         <= 3'b000;
            mem_drid_q       <= 3'b000;
            mem_cs_q         <= '0;
        end else if (ld_mem) begin
            mem_v_q          <= mem_v_in;
            mem_npc_q        <= mem_npc_in;
            mem_ir_q         <= mem_ir_in;
            mem_alu_result_q <= mem_alu_result_in;
            mem_address_q    <= mem_address_in;
            mem_cc_q         <= mem_cc_in;
            mem_drid_q       <= mem_drid_in;
            mem_cs_q         <= mem_cs_in;
        end
    end

    assign mem_v          = mem_v_q;
    assign mem_npc        = mem_npc_q;
    assign mem_ir         = mem_ir_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_address    = mem_address_q;
    assign mem_cc         = mem_cc_q;
    assign mem_drid       = mem_drid_q;
    assign mem_cs         = mem_cs_q;

endmodule

// File: tb/tb_lc3b_agex_stage.sv
// Directed-vector bench for lc3b_agex_stage with hand-computed expectations.
module tb_lc3b_agex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        agex_v;
    logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
    logic [2:0]  agex_cc, agex_drid;
    logic [19:0] agex_cs;
    logic        mem_stall;
    logic        ld_mem, mem_v_in, mem_v;
    logic [15:0] mem_npc_in, mem_ir_in, mem_alu_result_in, mem_address_in;
    logic [15:0] mem_npc, mem_ir, mem_alu_result, mem_address;
    logic [2:0]  mem_cc_in, mem_drid_in, mem_cc, mem_drid;
    logic [10:0] mem_cs_in, mem_cs;
    logic        v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall;

    int vectors = 0;
    int miscompares = 0;

    lc3b_agex_stage dut (
        .clk(clk), .reset(reset), .agex_v(agex_v), .agex_npc(agex_npc),
        .agex_ir(agex_ir), .agex_sr1(agex_sr1), .agex_sr2(agex_sr2),
        .agex_cc(agex_cc), .agex_drid(agex_drid), .agex_cs(agex_cs),
        .mem_stall(mem_stall), .ld_mem(ld_mem),
        .mem_v_in(mem_v_in), .mem_npc_in(mem_npc_in), .mem_ir_in(mem_ir_in),
        .mem_alu_result_in(mem_alu_result_in), .mem_address_in(mem_address_in),
        .mem_cc_in(mem_cc_in), .mem_drid_in(mem_drid_in), .mem_cs_in(mem_cs_in),
        .mem_v(mem_v), .mem_npc(mem_npc), .mem_ir(mem_ir),
        .mem_alu_result(mem_alu_result), .mem_address(mem_address),
        .mem_cc(mem_cc), .mem_drid(mem_drid), .mem_cs(mem_cs),
        .v_agex_ld_reg(v_agex_ld_reg), .v_agex_ld_cc(v_agex_ld_cc),
        .v_agex_br_stall(v_agex_br_stall)
    );

    always #5 clk = ~clk;

    // Control word: a1, a2mux[1:0], lshf1, amux, sr2mux, aluk[1:0], resultmux.
    function automatic logic [19:0] mkcs(input logic a1, input logic [1:0] a2,
                                         input logic lshf, input logic amux,
                                         input logic s2, input logic [1:0] aluk,
                                         input logic rmux);
        logic [19:0] c;
        c = 20'h0;
        c[0] = a1; c[1] = a2[1]; c[2] = a2[0]; c[3] = lshf; c[4] = amux;
        c[5] = s2; c[6] = aluk[1]; c[7] = aluk[0]; c[8] = rmux;
        return c;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        #2;
        vectors++;
        if ({mem_v, mem_npc, mem_ir, mem_alu_result, mem_address, mem_cc, mem_drid, mem_cs} !== 70'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%0b npc=%h addr=%h alu=%h cs=%h, want all 0",
                     mem_v, mem_npc, mem_address, mem_alu_result, mem_cs);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stall;
        @(negedge clk);
        agex_v = 1'b1; agex_npc = 16'h1234; agex_ir = 16'hABCD; agex_cc = 3'b010;
        agex_drid = 3'd5; agex_cs = 20'hFFE00; mem_stall = 1'b0;
        #1;
        vectors++;
        if (ld_mem !== 1'b1 || mem_v_in !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_off_comb: got ld_mem=%0b mem_v_in=%0b, want 1 1", ld_mem, mem_v_in);
        end
        vectors++;
        if (mem_cs_in !== 11'h7FF || mem_drid_in !== 3'd5 || mem_cc_in !== 3'b010 || mem_ir_in !== 16'hABCD) begin
            miscompares++;
            $display("FAIL passthrough: got cs=%h drid=%0d cc=%b ir=%h, want 7ff 5 010 abcd",
                     mem_cs_in, mem_drid_in, mem_cc_in, mem_ir_in);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_v !== 1'b1 || mem_npc !== 16'h1234 || mem_ir !== 16'hABCD || mem_cs !== 11'h7FF || mem_drid !== 3'd5) begin
            miscompares++;
            $display("FAIL latch_load: got v=%0b npc=%h ir=%h cs=%h drid=%0d, want 1 1234 abcd 7ff 5",
                     mem_v, mem_npc, mem_ir, mem_cs, mem_drid);
        end
        @(negedge clk);
        agex_v = 1'b0; agex_npc = 16'h5678; agex_ir = 16'h0000; agex_cs = 20'h0; mem_stall = 1'b1;
        #1;
        vectors++;
        if (ld_mem !== 1'b0 || mem_v_in !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_on_comb: got ld_mem=%0b mem_v_in=%0b, want 0 0", ld_mem, mem_v_in);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_v !== 1'b1 || mem_npc !== 16'h1234 || mem_ir !== 16'hABCD || mem_cs !== 11'h7FF) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%0b npc=%h ir=%h cs=%h, want 1 1234 abcd 7ff",
                     mem_v, mem_npc, mem_ir, mem_cs);
        end
        @(negedge clk);
        mem_stall = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (mem_v !== 1'b0 || mem_npc !== 16'h5678 || mem_cs !== 11'h000) begin
            miscompares++;
            $display("FAIL stall_release: got v=%0b npc=%h cs=%h, want 0 5678 000", mem_v, mem_npc, mem_cs);
        end
    endtask

    task automatic test_address;
        logic [15:0] exp [5];
        logic [15:0] got;
        for (int i = 0; i < 5; i++) begin
            agex_sr1 = 16'h1000; agex_npc = 16'h3002;
            case (i)
                0: begin agex_cs = mkcs(0, 2'b00, 0, 1, 0, 2'b00, 0); agex_ir = 16'h0000; exp[i] = 16'h3002; end
                1: begin agex_cs = mkcs(1, 2'b01, 0, 1, 0, 2'b00, 0); agex_ir = 16'h003C; exp[i] = 16'h0FFC; end
                2: begin agex_cs = mkcs(1, 2'b01, 1, 1, 0, 2'b00, 0); agex_ir = 16'h003C; exp[i] = 16'h0FF8; end
                3: begin agex_cs = mkcs(1, 2'b01, 0, 0, 0, 2'b00, 0); agex_ir = 16'h0020; exp[i] = 16'h0040; end
                default: begin
                    agex_npc = 16'h3000; agex_cs = mkcs(0, 2'b11, 0, 1, 0, 2'b00, 0);
                    agex_ir = 16'h0400; exp[i] = 16'h2C00;
                end
            endcase
            #1;
            got = mem_address_in;
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL address_%0d: got %h, want %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_alu;
        logic [15:0] exp;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin agex_cs = mkcs(0, 0, 0, 0, 0, 2'b00, 1); agex_sr1 = 16'h0003; agex_sr2 = 16'h0004; agex_ir = 16'h0000; exp = 16'h0007; end
                1: begin agex_cs = mkcs(0, 0, 0, 0, 1, 2'b01, 1); agex_sr1 = 16'h00F0; agex_sr2 = 16'h0000; agex_ir = 16'h001F; exp = 16'h00F0; end
                2: begin agex_cs = mkcs(0, 0, 0, 0, 0, 2'b10, 1); agex_sr1 = 16'h00FF; agex_sr2 = 16'h0F0F; agex_ir = 16'h0000; exp = 16'h0FF0; end
                3: begin agex_cs = mkcs(0, 0, 0, 0, 0, 2'b11, 1); agex_sr1 = 16'h5555; agex_sr2 = 16'hABCD; agex_ir = 16'h0000; exp = 16'h5555; end
                default: begin agex_cs = mkcs(0, 0, 0, 0, 1, 2'b00, 1); agex_sr1 = 16'hFFFF; agex_sr2 = 16'h0000; agex_ir = 16'h0001; exp = 16'h0000; end
            endcase
            #1;
            vectors++;
            if (mem_alu_result_in !== exp) begin
                miscompares++;
                $display("FAIL alu_%0d: got %h, want %h", i, mem_alu_result_in, exp);
            end
        end
    endtask

    task automatic test_shift;
        logic [15:0] exp;
        agex_cs = mkcs(0, 0, 0, 0, 0, 2'b00, 0);
        agex_sr2 = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin agex_sr1 = 16'h0001; agex_ir = 16'h0004; exp = 16'h0010; end
                1: begin agex_sr1 = 16'h8000; agex_ir = 16'h0011; exp = 16'h4000; end
                2: begin agex_sr1 = 16'h8000; agex_ir = 16'h0031; exp = 16'hC000; end
                default: begin agex_sr1 = 16'h8001; agex_ir = 16'h000F; exp = 16'h8000; end
            endcase
            #1;
            vectors++;
            if (mem_alu_result_in !== exp) begin
                miscompares++;
                $display("FAIL shift_%0d: got %h, want %h", i, mem_alu_result_in, exp);
            end
        end
    endtask

    task automatic test_hazard;
        agex_cs = 20'h0;
        agex_cs[12] = 1'b1; agex_cs[18] = 1'b1; agex_cs[19] = 1'b1;
        agex_v = 1'b1;
        #1;
        vectors++;
        if ({v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall} !== 3'b111) begin
            miscompares++;
            $display("FAIL hazard_valid: got %b, want 111", {v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall});
        end
        agex_v = 1'b0;
        #1;
        vectors++;
        if ({v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL hazard_invalid: got %b, want 000", {v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall});
        end
        agex_v = 1'b1; agex_cs = 20'h0; agex_cs[18] = 1'b1;
        #1;
        vectors++;
        if ({v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall} !== 3'b100) begin
            miscompares++;
            $display("FAIL hazard_ldreg_only: got %b, want 100", {v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall});
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        agex_v = 1'b1; agex_npc = 16'h4444; agex_ir = 16'h0000; agex_sr1 = 16'h0003;
        agex_sr2 = 16'h0004; agex_cc = 3'b100; agex_drid = 3'd7;
        agex_cs = mkcs(0, 2'b00, 0, 1, 0, 2'b00, 1); mem_stall = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (mem_npc !== 16'h4444 || mem_alu_result !== 16'h0007 || mem_address !== 16'h4444 || mem_v !== 1'b1) begin
            miscompares++;
            $display("FAIL preload: got v=%0b npc=%h alu=%h addr=%h, want 1 4444 0007 4444",
                     mem_v, mem_npc, mem_alu_result, mem_address);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({mem_v, mem_npc, mem_ir, mem_alu_result, mem_address, mem_cc, mem_drid, mem_cs} !== 70'h0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%0b npc=%h alu=%h addr=%h cc=%b drid=%0d, want all 0",
                     mem_v, mem_npc, mem_alu_result, mem_address, mem_cc, mem_drid);
        end
        vectors++;
        if (mem_npc_in !== 16'h4444 || mem_alu_result_in !== 16'h0007 || ld_mem !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_comb: got npc_in=%h alu_in=%h ld_mem=%0b, want 4444 0007 1",
                     mem_npc_in, mem_alu_result_in, ld_mem);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_npc !== 16'h0000 || mem_v !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held: got v=%0b npc=%h, want 0 0000", mem_v, mem_npc);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; agex_v = 1'b0; agex_npc = 16'h0; agex_ir = 16'h0; agex_sr1 = 16'h0;
        agex_sr2 = 16'h0; agex_cc = 3'b0; agex_drid = 3'b0; agex_cs = 20'h0; mem_stall = 1'b0;
        #1;
        test_reset;
        test_stall;
        test_address;
        test_alu;
        test_shift;
        test_hazard;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
